vt52_command_handler: RTL and testbench
=======================================

Name: vt52_command_handler

Overview:
- Upstream of the video top level. Consumes received bytes over a valid/ready handshake and interprets VT52 printable characters, control codes and escape sequences.
- Drives the character-buffer write port: address, data and write enable.
- Drives the cursor_position load interface: new X, new Y and write strobe.
- Screen is 64 columns x 16 rows. Buffer address is {row, col}.

Parameters:
- COL_BITS, 6, column index width (64 columns).
- ROW_BITS, 4, row index width (16 rows).
- CLEAR_CHAR, 8'h20, fill code written by the clear commands.
- TAB_STOP, 8, tab stop spacing. Must be a power of two.

Ports:
- px_clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- data_in  in  8  received byte
- valid_in  in  1  data_in valid
- ready_out  out  1  handler can accept a byte
- buffer_addr  out  COL_BITS+ROW_BITS  char buffer write address {row, col}
- buffer_din  out  8  char buffer write data
- buffer_wen  out  1  char buffer write enable
- new_cursor_x  out  COL_BITS  cursor column to load
- new_cursor_y  out  ROW_BITS  cursor row to load
- write_cursor_pos  out  1  cursor load strobe

Behaviour:
- Reset:
  - State IDLE; internal cursor (cx, cy) = (0, 0).
  - ready_out = 1.
  - buffer_wen = 0, write_cursor_pos = 0, buffer_addr = 0, buffer_din = 0, new_cursor_x = 0, new_cursor_y = 0.
  - Reset mid-clear aborts the clear immediately.
- Handshake:
  - A byte is accepted on a px_clk rising edge when valid_in && ready_out.
  - ready_out = 1 in IDLE, ESC, YROW and YCOL; 0 in CLEAR.
- Output timing:
  - All outputs are registered. Effects of an accepted byte appear on the next cycle.
  - buffer_wen and write_cursor_pos are single-cycle pulses.
  - new_cursor_x/new_cursor_y always hold the updated (cx, cy) and are valid while write_cursor_pos = 1.
  - write_cursor_pos pulses after every accepted byte that ends a command, even if the cursor is unchanged.
- IDLE byte decode:
  - 0x20-0x7E: buffer_addr = {cy, cx}, buffer_din = byte, buffer_wen pulses. Then cx = min(cx+1, 63). No autowrap: a character written at column 63 leaves cx at 63, so the next character overwrites it.
  - 0x0D CR: cx = 0.
  - 0x0A LF: cy = min(cy+1, 15). No scrolling.
  - 0x08 BS: cx = max(cx-1, 0).
  - 0x09 TAB: cx = min((cx | (TAB_STOP-1)) + 1, 63).
  - 0x1B: go to ESC. No strobe.
  - All other codes, including 0x7F and 0x07: ignored. No pulses.
- ESC byte decode (the next byte):
  - 'A': cy = max(cy-1, 0).
  - 'B': cy = min(cy+1, 15).
  - 'C': cx = min(cx+1, 63).
  - 'D': cx = max(cx-1, 0).
  - 'H': (0, 0).
  - 'Y': go to YROW.
  - 'J': go to CLEAR; end address = {15, 63}.
  - 'K': go to CLEAR; end address = {cy, 63}.
  - 0x1B: stay in ESC.
  - Anything else: back to IDLE, no effect.
  - A/B/C/D/H return to IDLE with a cursor strobe.
- Direct cursor address (ESC Y):
  - YROW: latch r = byte - 0x20. Go to YCOL.
  - YCOL: c = byte - 0x20. Set cy = min(r, 15), cx = min(c, 63), strobe, return to IDLE.
  - Bytes below 0x20 are treated as 0, because the subtraction saturates at 0.
- CLEAR state:
  - Write pointer p starts at {cy, cx}.
  - Each cycle: buffer_addr = p, buffer_din = CLEAR_CHAR, buffer_wen = 1.
  - When p equals the end address: the last write occurs that cycle, and on the next cycle the handler returns to IDLE with ready_out = 1 and a cursor strobe.
  - Cursor position is unchanged.
  - Write count = end - start + 1. For example, ESC J at (0, 0) gives 1024 writes; ESC K at cx = 63 gives 1 write.
- Simultaneous events: valid_in is ignored while ready_out = 0. The byte is held by the sender.

Test Plan:
- Reset, then send 'A' (0x41) → next cycle buffer_wen = 1, addr = 0, din = 0x41, write_cursor_pos = 1, new_cursor_x = 1, new_cursor_y = 0.
- Send 64 × 'x' then 'y' → the 'y' write has addr = {0, 63}; new_cursor_x stays 63. Then send CR, LF → cursor (0, 1).
- Send ESC Y 0x2F 0x5F then 'Z' → cursor loads (col 63, row 15); 'Z' written at addr 1023. Send ESC Y 0x7F 0x7F → clamped to (63, 15).
- With cursor at (60, 3), send ESC K → exactly 4 consecutive writes at addr 252-255, din 0x20; ready_out low for 4 cycles; cursor stays (60, 3).
- ESC J from (0, 0) → 1024 writes. Assert clr after 100 writes → all outputs 0, ready_out = 1, state IDLE.
- BS at column 0, ESC A at row 0, TAB at column 5 then at column 62 → column 0, row 0, column 8, column 63. Sending ESC 'Q' → no pulses, and the next 'a' is written normally.

Source files
------------

// File: rtl/vt52_command_handler.sv
// rtl/vt52_command_handler.sv - VT52 byte interpreter driving the char buffer and cursor load ports
module vt52_command_handler #(
    parameter int         COL_BITS   = 6,
    parameter int         ROW_BITS   = 4,
    parameter logic [7:0] CLEAR_CHAR = 8'h20,
    parameter int         TAB_STOP   = 8
) (
    input  logic                         px_clk,
    input  logic                         clr,
    input  logic [7:0]                   data_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic [COL_BITS+ROW_BITS-1:0] buffer_addr,
    output logic [7:0]                   buffer_din,
    output logic                         buffer_wen,
    output logic [COL_BITS-1:0]          new_cursor_x,
    output logic [ROW_BITS-1:0]          new_cursor_y,
    output logic                         write_cursor_pos
);

    localparam int AW = COL_BITS + ROW_BITS;
    localparam logic [COL_BITS-1:0] COL_MAX = '1;
    localparam logic [ROW_BITS-1:0] ROW_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_ESC, S_YROW, S_YCOL, S_CLEAR} state_t;

    state_t              state;
    logic [COL_BITS-1:0] cx;
    logic [ROW_BITS-1:0] cy;
    logic [7:0]          row_lat;
    logic [AW-1:0]       clr_ptr;
    logic [AW-1:0]       clr_end;
    logic                clr_done;
    logic                accept;

    assign accept       = valid_in && ready_out;
    assign new_cursor_x = cx;
    assign new_cursor_y = cy;

    function automatic logic [COL_BITS-1:0] col_inc(input logic [COL_BITS-1:0] c);
        return (c == COL_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [COL_BITS-1:0] col_dec(input logic [COL_BITS-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [ROW_BITS-1:0] row_inc(input logic [ROW_BITS-1:0] r);
        return (r == ROW_MAX) ? r : r + 1'b1;
    endfunction

    function automatic logic [ROW_BITS-1:0] row_dec(input logic [ROW_BITS-1:0] r);
        return (r == '0) ? r : r - 1'b1;
    endfunction

    // Next tab stop; the extra carry bit catches stepping past the last column.
    function automatic logic [COL_BITS-1:0] col_tab(input logic [COL_BITS-1:0] c);
        logic [COL_BITS:0] t;
        t = {1'b0, c | COL_BITS'(TAB_STOP - 1)} + 1'b1;
        return t[COL_BITS] ? COL_MAX : t[COL_BITS-1:0];
    endfunction

    function automatic logic [7:0] sat_sub20(input logic [7:0] b);
        return (b < 8'h20) ? 8'h00 : b - 8'h20;
    endfunction

    function automatic logic [COL_BITS-1:0] col_clamp(input logic [7:0] v);
        return (v > 8'(COL_MAX)) ? COL_MAX : v[COL_BITS-1:0];
    endfunction

    function automatic logic [ROW_BITS-1:0] row_clamp(input logic [7:0] v);
        return (v > 8'(ROW_MAX)) ? ROW_MAX : v[ROW_BITS-1:0];
    endfunction

    always_ff @(posedge px_clk or posedge clr) begin
        if (clr) begin
            state            <= S_IDLE;
            cx               <= '0;
            cy               <= '0;
            row_lat          <= '0;
            clr_ptr          <= '0;
            clr_end          <= '0;
            clr_done         <= 1'b0;
            ready_out        <= 1'b1;
            buffer_addr      <= '0;
            buffer_din       <= '0;
            buffer_wen       <= 1'b0;
            write_cursor_pos <= 1'b0;
        end else begin
            buffer_wen       <= 1'b0;
            write_cursor_pos <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (data_in >= 8'h20 && data_in <= 8'h7e) begin
                            buffer_addr      <= {cy, cx};
                            buffer_din       <= data_in;
                            buffer_wen       <= 1'b1;
                            cx               <= col_inc(cx);
                            write_cursor_pos <= 1'b1;
                        end else begin
                            case (data_in)
                                8'h0d: begin cx <= '0;          write_cursor_pos <= 1'b1; end
                                8'h0a: begin cy <= row_inc(cy); write_cursor_pos <= 1'b1; end
                                8'h08: begin cx <= col_dec(cx); write_cursor_pos <= 1'b1; end
                                8'h09: begin cx <= col_tab(cx); write_cursor_pos <= 1'b1; end
                                8'h1b: state <= S_ESC;
                                default: ;
                            endcase
                        end
                    end
                end
                S_ESC: begin
                    if (accept) begin
                        state <= S_IDLE;
                        case (data_in)
                            8'h41: begin cy <= row_dec(cy); write_cursor_pos <= 1'b1; end
                            8'h42: begin cy <= row_inc(cy); write_cursor_pos <= 1'b1; end
                            8'h43: begin cx <= col_inc(cx); write_cursor_pos <= 1'b1; end
                            8'h44: begin cx <= col_dec(cx); write_cursor_pos <= 1'b1; end
                            8'h48: begin cx <= '0; cy <= '0; write_cursor_pos <= 1'b1; end
                            8'h59: state <= S_YROW;
                            8'h1b: state <= S_ESC;
                            8'h4a, 8'h4b: begin
                                // First fill write goes out with the command itself so the
                                // busy window covers exactly the fill writes.
                                state       <= S_CLEAR;
                                ready_out   <= 1'b0;
                                buffer_addr <= {cy, cx};
                                buffer_din  <= CLEAR_CHAR;
                                buffer_wen  <= 1'b1;
                                clr_ptr     <= {cy, cx} + 1'b1;
                                if (data_in == 8'h4a) begin
                                    clr_end  <= {ROW_MAX, COL_MAX};
                                    clr_done <= ({cy, cx} == {ROW_MAX, COL_MAX});
                                end else begin
                                    clr_end  <= {cy, COL_MAX};
                                    clr_done <= (cx == COL_MAX);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_YROW: begin
                    if (accept) begin
                        row_lat <= sat_sub20(data_in);
                        state   <= S_YCOL;
                    end
                end
                S_YCOL: begin
                    if (accept) begin
                        cy               <= row_clamp(row_lat);
                        cx               <= col_clamp(sat_sub20(data_in));
                        write_cursor_pos <= 1'b1;
                        state            <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (clr_done) begin
                        state            <= S_IDLE;
                        ready_out        <= 1'b1;
                        write_cursor_pos <= 1'b1;
                    end else begin
                        buffer_addr <= clr_ptr;
                        buffer_din  <= CLEAR_CHAR;
                        buffer_wen  <= 1'b1;
                        if (clr_ptr == clr_end) begin
                            clr_done <= 1'b1;
                        end else begin
                            clr_ptr <= clr_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vt52_command_handler.sv
// tb/tb_vt52_command_handler.sv - table, hand-sequence and randomized checks for vt52_command_handler
module tb_vt52_command_handler;

    logic       px_clk = 1'b0;
    logic       clr;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic [9:0] buffer_addr;
    logic [7:0] buffer_din;
    logic       buffer_wen;
    logic [5:0] new_cursor_x;
    logic [3:0] new_cursor_y;
    logic       write_cursor_pos;

    int vectors = 0;
    int errors  = 0;

    vt52_command_handler dut (
        .px_clk(px_clk), .clr(clr), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .buffer_addr(buffer_addr), .buffer_din(buffer_din),
        .buffer_wen(buffer_wen), .new_cursor_x(new_cursor_x), .new_cursor_y(new_cursor_y),
        .write_cursor_pos(write_cursor_pos)
    );

    always #5 px_clk = ~px_clk;

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        bit         wen;
        int         addr;
        int         din;
        bit         wcp;
        int         x;
        int         y;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] b, input bit w, input int a, input int d,
                       input bit s, input int x, input int y);
        vec_t v;
        v.b = b; v.wen = w; v.addr = a; v.din = d; v.wcp = s; v.x = x; v.y = y;
        tbl.push_back(v);
    endtask

    // Reference model: cursor as plain integers, escape sequences collected in a queue
    int         mcx, mcy;
    logic [7:0] esc_q[$];
    int         ew_addr[$];
    int         ew_din[$];
    bit         estrobe, eclear;

    task automatic model_byte(input logic [7:0] b);
        int r, c, last;
        ew_addr.delete(); ew_din.delete(); estrobe = 0; eclear = 0;
        if (esc_q.size() == 0) begin
            if (b >= 8'h20 && b <= 8'h7e) begin
                ew_addr.push_back(mcy * 64 + mcx); ew_din.push_back(int'(b));
                mcx = (mcx < 63) ? mcx + 1 : 63; estrobe = 1;
            end else if (b == 8'h0d) begin mcx = 0; estrobe = 1; end
            else if (b == 8'h0a) begin mcy = (mcy < 15) ? mcy + 1 : 15; estrobe = 1; end
            else if (b == 8'h08) begin mcx = (mcx > 0) ? mcx - 1 : 0; estrobe = 1; end
            else if (b == 8'h09) begin
                mcx = ((mcx / 8) + 1) * 8; if (mcx > 63) mcx = 63; estrobe = 1;
            end else if (b == 8'h1b) esc_q.push_back(b);
        end else if (esc_q.size() == 1) begin
            esc_q.delete();
            case (b)
                8'h41: begin mcy = (mcy > 0) ? mcy - 1 : 0; estrobe = 1; end
                8'h42: begin mcy = (mcy < 15) ? mcy + 1 : 15; estrobe = 1; end
                8'h43: begin mcx = (mcx < 63) ? mcx + 1 : 63; estrobe = 1; end
                8'h44: begin mcx = (mcx > 0) ? mcx - 1 : 0; estrobe = 1; end
                8'h48: begin mcx = 0; mcy = 0; estrobe = 1; end
                8'h59: begin esc_q.push_back(8'h1b); esc_q.push_back(b); end
                8'h1b: esc_q.push_back(b);
                8'h4a, 8'h4b: begin
                    last = (b == 8'h4a) ? 1023 : mcy * 64 + 63;
                    for (int a = mcy * 64 + mcx; a <= last; a++) begin
                        ew_addr.push_back(a); ew_din.push_back(32'h20);
                    end
                    estrobe = 1; eclear = 1;
                end
                default: ;
            endcase
        end else if (esc_q.size() == 2) begin
            esc_q.push_back(b);
        end else begin
            r = (esc_q[2] >= 8'h20) ? int'(esc_q[2]) - 32 : 0;
            c = (b >= 8'h20) ? int'(b) - 32 : 0;
            mcy = (r > 15) ? 15 : r;
            mcx = (c > 63) ? 63 : c;
            estrobe = 1;
            esc_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ready"}, int'(ready_out), 1);
        chk({nm, "_wen"}, int'(buffer_wen), 0);
        chk({nm, "_wcp"}, int'(write_cursor_pos), 0);
        chk({nm, "_addr"}, int'(buffer_addr), 0);
        chk({nm, "_din"}, int'(buffer_din), 0);
        chk({nm, "_x"}, int'(new_cursor_x), 0);
        chk({nm, "_y"}, int'(new_cursor_y), 0);
    endtask

    task automatic do_reset();
        @(negedge px_clk);
        clr = 1'b1; valid_in = 1'b0;
        @(negedge px_clk);
        check_reset_outputs("reset");
        clr = 1'b0;
        mcx = 0; mcy = 0; esc_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge px_clk);
        data_in = b; valid_in = 1'b1;
        @(posedge px_clk);
        #1 valid_in = 1'b0;
        @(negedge px_clk);
    endtask

    // Sends one byte and compares everything it produced against the model.
    task automatic check_byte(input logic [7:0] b);
        int gw_addr[$], gw_din[$];
        int nstrobe = 0, lowcyc = 0, cyc = 0, bad = -1, n;
        model_byte(b);
        @(negedge px_clk);
        data_in = b; valid_in = 1'b1;
        @(posedge px_clk);
        #1 valid_in = 1'b0;
        do begin
            @(negedge px_clk);
            if (buffer_wen) begin
                gw_addr.push_back(int'(buffer_addr)); gw_din.push_back(int'(buffer_din));
            end
            if (write_cursor_pos) begin
                nstrobe++;
                chk("strobe_x", int'(new_cursor_x), mcx);
                chk("strobe_y", int'(new_cursor_y), mcy);
            end
            if (!ready_out) lowcyc++;
            cyc++;
        end while (!ready_out && cyc < 1100);
        chk("ready_returns", int'(ready_out), 1);
        chk("write_count", gw_addr.size(), ew_addr.size());
        n = (gw_addr.size() < ew_addr.size()) ? gw_addr.size() : ew_addr.size();
        for (int i = 0; i < n && bad < 0; i++)
            if (gw_addr[i] != ew_addr[i] || gw_din[i] != ew_din[i]) bad = i;
        chk("first_bad_write_index", bad, -1);
        chk("strobe_count", nstrobe, int'(estrobe));
        chk("busy_cycles", lowcyc, eclear ? ew_addr.size() : 0);
        chk("cursor_x", int'(new_cursor_x), mcx);
        chk("cursor_y", int'(new_cursor_y), mcy);
    endtask

    initial begin
        clr = 1'b1; data_in = 8'h00; valid_in = 1'b0;
        repeat (2) @(negedge px_clk);
        check_reset_outputs("init");
        clr = 1'b0;

        add(8'h41, 1, 0,   8'h41, 1, 1, 0);
        add(8'h0d, 0, 0,   0,     1, 0, 0);
        add(8'h0a, 0, 0,   0,     1, 0, 1);
        add(8'h08, 0, 0,   0,     1, 0, 1);
        add(8'h09, 0, 0,   0,     1, 8, 1);
        add(8'h62, 1, 72,  8'h62, 1, 9, 1);
        add(8'h07, 0, 0,   0,     0, 9, 1);
        add(8'h7f, 0, 0,   0,     0, 9, 1);
        add(8'h1b, 0, 0,   0,     0, 9, 1);
        add(8'h41, 0, 0,   0,     1, 9, 0);
        add(8'h1b, 0, 0,   0,     0, 9, 0);
        add(8'h41, 0, 0,   0,     1, 9, 0);
        add(8'h1b, 0, 0,   0,     0, 9, 0);
        add(8'h51, 0, 0,   0,     0, 9, 0);
        add(8'h61, 1, 9,   8'h61, 1, 10, 0);
        add(8'h1b, 0, 0,   0,     0, 10, 0);
        add(8'h59, 0, 0,   0,     0, 10, 0);
        add(8'h2f, 0, 0,   0,     0, 10, 0);
        add(8'h5f, 0, 0,   0,     1, 63, 15);
        add(8'h5a, 1, 1023, 8'h5a, 1, 63, 15);
        add(8'h1b, 0, 0,   0,     0, 63, 15);
        add(8'h48, 0, 0,   0,     1, 0, 0);
        add(8'h1b, 0, 0,   0,     0, 0, 0);
        add(8'h59, 0, 0,   0,     0, 0, 0);
        add(8'h7f, 0, 0,   0,     0, 0, 0);
        add(8'h7f, 0, 0,   0,     1, 63, 15);
        add(8'h1b, 0, 0,   0,     0, 63, 15);
        add(8'h43, 0, 0,   0,     1, 63, 15);
        add(8'h1b, 0, 0,   0,     0, 63, 15);
        add(8'h42, 0, 0,   0,     1, 63, 15);
        add(8'h1b, 0, 0,   0,     0, 63, 15);
        add(8'h44, 0, 0,   0,     1, 62, 15);
        add(8'h09, 0, 0,   0,     1, 63, 15);
        add(8'h1b, 0, 0,   0,     0, 63, 15);
        add(8'h59, 0, 0,   0,     0, 63, 15);
        add(8'h20, 0, 0,   0,     0, 63, 15);
        add(8'h25, 0, 0,   0,     1, 5, 0);
        add(8'h09, 0, 0,   0,     1, 8, 0);
        add(8'h1b, 0, 0,   0,     0, 8, 0);
        add(8'h59, 0, 0,   0,     0, 8, 0);
        add(8'h10, 0, 0,   0,     0, 8, 0);
        add(8'h10, 0, 0,   0,     1, 0, 0);

        foreach (tbl[i]) begin
            send_byte(tbl[i].b);
            chk($sformatf("tbl%0d_wen", i), int'(buffer_wen), int'(tbl[i].wen));
            if (tbl[i].wen) begin
                chk($sformatf("tbl%0d_addr", i), int'(buffer_addr), tbl[i].addr);
                chk($sformatf("tbl%0d_din", i), int'(buffer_din), tbl[i].din);
            end
            chk($sformatf("tbl%0d_wcp", i), int'(write_cursor_pos), int'(tbl[i].wcp));
            chk($sformatf("tbl%0d_x", i), int'(new_cursor_x), tbl[i].x);
            chk($sformatf("tbl%0d_y", i), int'(new_cursor_y), tbl[i].y);
        end

        // Right margin: no autowrap, then CR LF
        do_reset();
        repeat (64) check_byte(8'h78);
        check_byte(8'h79);
        chk("y_at_col63_addr", int'(buffer_addr), 63);
        check_byte(8'h0d);
        check_byte(8'h0a);
        chk("crlf_x", int'(new_cursor_x), 0);
        chk("crlf_y", int'(new_cursor_y), 1);

        // ESC K at (60,3) with the next byte held on the interface during the fill
        do_reset();
        check_byte(8'h1b); check_byte(8'h59); check_byte(8'h23); check_byte(8'h5c);
        check_byte(8'h1b);
        @(negedge px_clk);
        data_in = 8'h4b; valid_in = 1'b1;
        @(posedge px_clk);
        #1 data_in = 8'h71;
        for (int k = 1; k <= 6; k++) begin
            @(negedge px_clk);
            chk($sformatf("eraseline_c%0d_wen", k), int'(buffer_wen), (k <= 4 || k == 6) ? 1 : 0);
            chk($sformatf("eraseline_c%0d_ready", k), int'(ready_out), (k <= 4) ? 0 : 1);
            chk($sformatf("eraseline_c%0d_wcp", k), int'(write_cursor_pos), (k >= 5) ? 1 : 0);
            if (k <= 4) begin
                chk($sformatf("eraseline_c%0d_addr", k), int'(buffer_addr), 251 + k);
                chk($sformatf("eraseline_c%0d_din", k), int'(buffer_din), 32'h20);
            end
            if (k == 5) begin
                chk("eraseline_x", int'(new_cursor_x), 60);
                chk("eraseline_y", int'(new_cursor_y), 3);
            end
            if (k == 6) begin
                chk("held_byte_addr", int'(buffer_addr), 252);
                chk("held_byte_din", int'(buffer_din), 32'h71);
                chk("held_byte_x", int'(new_cursor_x), 61);
                valid_in = 1'b0;
            end
        end

        // Full screen clear, then a second one aborted by reset after 100 writes
        do_reset();
        check_byte(8'h1b);
        check_byte(8'h4a);
        chk("full_clear_writes", ew_addr.size(), 1024);
        check_byte(8'h1b);
        @(negedge px_clk);
        data_in = 8'h4a; valid_in = 1'b1;
        @(posedge px_clk);
        #1 valid_in = 1'b0;
        begin
            int n = 0;
            for (int c = 0; c < 200 && n < 100; c++) begin
                @(negedge px_clk);
                if (buffer_wen) n++;
            end
            chk("writes_before_abort", n, 100);
        end
        clr = 1'b1;
        #1 check_reset_outputs("abort");
        @(negedge px_clk);
        clr = 1'b0;
        mcx = 0; mcy = 0; esc_q.delete();
        check_byte(8'h41);

        // Randomized byte stream against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [7:0] b;
            logic [7:0] picks [6];
            logic [7:0] ctl [7];
            picks = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h59};
            ctl   = '{8'h0d, 8'h0a, 8'h08, 8'h09, 8'h07, 8'h7f, 8'h00};
            r = int'($urandom_range(0, 99));
            if (r < 25)      b = 8'h1b;
            else if (r < 40) b = picks[$urandom_range(0, 5)];
            else if (r < 43) b = 8'h4b;
            else if (r == 43) b = 8'h4a;
            else if (r < 60) b = ctl[$urandom_range(0, 6)];
            else             b = 8'($urandom_range(0, 255));
            check_byte(b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
